three_line_buffer: RTL and testbench

Row-delay line buffer that feeds the 3×3 window stage. It takes an HDMI pixel pack and stores the two previous active lines in on-chip RAM. It emits the delayed pack plus three vertically aligned 24-bit taps: the same x column from two lines ago, the previous line and the current line. It sits directly upstream of the window/matrix stage and drives its `i_pack_3`, `line1`, `line2` and `line3` inputs.

---
 rtl/hdmi_pkg.sv | 30 +++
 rtl/line_ram.sv | 37 +++
 rtl/three_line_buffer.sv | 130 +++++++++++++
 tb/tb_three_line_buffer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// HDMI pixel-pack layout shared by the line buffer and its neighbours: pack sizing, field offsets, tap struct.
package hdmi_pkg;

    localparam int unsigned CH_W      = 8;
    localparam int unsigned RGB_W     = 3 * CH_W;
    localparam int unsigned CTRL_W    = 4;
    localparam int unsigned H_ACT_DEF = 1280;
    localparam int unsigned V_ACT_DEF = 720;
    localparam int unsigned FILL_MAX  = 2;

    // Pack is {clk, hsync, vsync, de, r, g, b, x, y}; offsets below are relative to the top of {x, y}
    localparam int unsigned OFF_B   = 0;
    localparam int unsigned OFF_G   = CH_W;
    localparam int unsigned OFF_R   = 2 * CH_W;
    localparam int unsigned OFF_DE  = RGB_W;
    localparam int unsigned OFF_VS  = RGB_W + 1;
    localparam int unsigned OFF_HS  = RGB_W + 2;
    localparam int unsigned OFF_CLK = RGB_W + 3;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] b;
        logic [CH_W-1:0] g;
    } rgb_t;

    function automatic int unsigned hdmi_pack_size(input int unsigned h_act, input int unsigned v_act);
        return RGB_W + CTRL_W + 32'($clog2(h_act)) + 32'($clog2(v_act));
    endfunction

endpackage

// File: rtl/line_ram.sv
// Single-clock line RAM: synchronous read-first read port plus an independent write port.
module line_ram #(
    parameter int unsigned DEPTH = 1280,
    parameter int unsigned WIDTH = 24,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register samples the pre-write contents, so a same-address write returns old data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/three_line_buffer.sv
// Two-line delay buffer producing vertically aligned taps for the 3x3 window stage.
// THREE_LINE_BUFFER_FILL_ZERO_EN blanks taps that would reach above the frame's top edge.
module three_line_buffer
    import hdmi_pkg::*;
#(
    parameter int unsigned H_ACT      = H_ACT_DEF,
    parameter int unsigned V_ACT      = V_ACT_DEF,
    localparam int unsigned PACK_SIZE = hdmi_pack_size(H_ACT, V_ACT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PACK_SIZE-1:0] i_pack,
    output logic [PACK_SIZE-1:0] o_pack,
    output logic [RGB_W-1:0]     line1,
    output logic [RGB_W-1:0]     line2,
    output logic [RGB_W-1:0]     line3
);

    localparam int unsigned XW = $clog2(H_ACT);
    localparam int unsigned YW = $clog2(V_ACT);
    localparam int unsigned CB = XW + YW;

    logic [XW-1:0]        x_c;
    logic                 de_c;
    rgb_t                 pix_c;
    logic                 unused_clk_c;

    logic [PACK_SIZE-2:0] pack_q;
    logic                 de_q;
    logic [XW-1:0]        x_q;
    rgb_t                 line3_q;
    rgb_t                 l0_rd;
    rgb_t                 l1_rd;

    // hdmi_unpack: pull the fields the buffer needs out of the incoming pack
    assign x_c          = i_pack[YW +: XW];
    assign de_c         = i_pack[CB + OFF_DE];
    assign pix_c.r      = i_pack[CB + OFF_R +: CH_W];
    assign pix_c.g      = i_pack[CB + OFF_G +: CH_W];
    assign pix_c.b      = i_pack[CB + OFF_B +: CH_W];
    assign unused_clk_c = i_pack[CB + OFF_CLK];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_q  <= '0;
            de_q    <= 1'b0;
            x_q     <= '0;
            line3_q <= '0;
        end else begin
            pack_q <= i_pack[PACK_SIZE-2:0];
            de_q   <= de_c;
            if (de_c) begin
                x_q     <= x_c;
                line3_q <= pix_c;
            end
        end
    end

    // hdmi_pack: delayed fields with the clock field taken from the live clock
    assign o_pack = {clk, pack_q};
    assign line3  = line3_q;

    line_ram #(.DEPTH(H_ACT), .WIDTH(RGB_W)) u_l0 (
        .clk_i   (clk),
        .rst_i   (rst),
        .re_i    (de_c),
        .raddr_i (x_c),
        .we_i    (de_c),
        .waddr_i (x_c),
        .wdata_i (pix_c),
        .rdata_o (l0_rd)
    );

    // Old L0 word only exists after the read, so it lands in L1 one cycle later at the same column
    line_ram #(.DEPTH(H_ACT), .WIDTH(RGB_W)) u_l1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .re_i    (de_c),
        .raddr_i (x_c),
        .we_i    (de_q),
        .waddr_i (x_q),
        .wdata_i (l0_rd),
        .rdata_o (l1_rd)
    );

`ifdef THREE_LINE_BUFFER_FILL_ZERO_EN
    logic       vs_c;
    logic       vs_q;
    logic       vs_rise_c;
    logic       de_fall_c;
    logic [1:0] fill_q;
    logic [1:0] fill_d;
    logic [1:0] fill_cur_c;
    logic [1:0] fill_tap_q;

    assign vs_c = i_pack[CB + OFF_VS];

    // Completed-line count since vsync; a coincident vsync edge overrides the line-end increment
    always_comb begin
        vs_rise_c  = vs_c & ~vs_q;
        de_fall_c  = de_q & ~de_c;
        fill_cur_c = vs_rise_c ? 2'd0 : fill_q;
        fill_d     = fill_cur_c;
        if (!vs_rise_c && de_fall_c && (fill_q != 2'(FILL_MAX))) begin
            fill_d = fill_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q       <= 1'b0;
            fill_q     <= 2'd0;
            fill_tap_q <= 2'd0;
        end else begin
            vs_q   <= vs_c;
            fill_q <= fill_d;
            if (de_c) begin
                fill_tap_q <= fill_cur_c;
            end
        end
    end

    assign line2 = (fill_tap_q == 2'd0)            ? '0 : l0_rd;
    assign line1 = (fill_tap_q < 2'(FILL_MAX))     ? '0 : l1_rd;
`else
    assign line2 = l0_rd;
    assign line1 = l1_rd;
`endif

endmodule

// File: tb/tb_three_line_buffer.sv
// Directed bench for three_line_buffer at H_ACT=8, V_ACT=6 (34-bit pack); follows THREE_LINE_BUFFER_FILL_ZERO_EN.
module tb_three_line_buffer;

    localparam int unsigned PW = 34;

`ifdef THREE_LINE_BUFFER_FILL_ZERO_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] i_pack;
    logic [PW-1:0] o_pack;
    logic [23:0]   line1;
    logic [23:0]   line2;
    logic [23:0]   line3;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    three_line_buffer #(.H_ACT(8), .V_ACT(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_pack (i_pack),
        .o_pack (o_pack),
        .line1  (line1),
        .line2  (line2),
        .line3  (line3)
    );

    always #5 clk = ~clk;

    // {clk, hsync, vsync, de, r, g, b, x, y}
    function automatic logic [PW-1:0] mk(input logic vs, input logic de, input logic [7:0] r,
                                         input logic [7:0] g, input logic [7:0] b,
                                         input logic [2:0] x, input logic [2:0] y);
        return {1'b0, 1'b0, vs, de, r, g, b, x, y};
    endfunction

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Apply at a falling edge; outputs for that input are visible at the next falling edge
    task automatic drive(input logic [PW-1:0] p);
        i_pack = p;
        step();
    endtask

    task automatic pix(input logic [2:0] x, input logic [2:0] y, input bit white);
        drive(mk(1'b0, 1'b1, white ? 8'hFF : 8'(y), white ? 8'hFF : 8'h00,
                 white ? 8'hFF : 8'(x), x, y));
    endtask

    task automatic blank(input logic vs);
        drive(mk(vs, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0));
    endtask

    task automatic part_line(input logic [2:0] y, input int x0, input int x1, input bit white);
        for (int x = x0; x <= x1; x++) begin
            pix(3'(x), y, white);
        end
    endtask

    task automatic check_taps(input string tag, input logic [23:0] e3, input logic [23:0] e2,
                              input logic [23:0] e1);
        chk({tag, "_line3"}, PW'(line3), PW'(e3));
        chk({tag, "_line2"}, PW'(line2), PW'(e2));
        chk({tag, "_line1"}, PW'(line1), PW'(e1));
    endtask

    initial begin
        rst    = 1'b1;
        i_pack = mk(1'b1, 1'b1, 8'hAA, 8'h55, 8'h33, 3'd4, 3'd2);
        step();
        step();
        chk("reset_opack", o_pack, '0);
        check_taps("reset", 24'h0, 24'h0, 24'h0);
        rst = 1'b0;

        // Frame A: solid white
        blank(1'b1);
        blank(1'b0);
        for (int y = 0; y < 6; y++) begin
            part_line(3'(y), 0, 7, 1'b1);
            blank(1'b0);
            blank(1'b0);
        end
        chk("a_hold_line3", PW'(line3), PW'(24'hFFFFFF));

        // Frame B: ramp {r=y, b=x, g=0}
        blank(1'b1);
        blank(1'b0);
        part_line(3'd0, 0, 2, 1'b0);
        check_taps("b_y0x2", 24'h000200, ZERO_EN ? 24'h0 : 24'hFFFFFF, ZERO_EN ? 24'h0 : 24'hFFFFFF);
        part_line(3'd0, 3, 7, 1'b0);
        blank(1'b0);
        blank(1'b0);

        part_line(3'd1, 0, 6, 1'b0);
        check_taps("b_y1x6", 24'h010600, 24'h000600, ZERO_EN ? 24'h0 : 24'hFFFFFF);
        part_line(3'd1, 7, 7, 1'b0);
        blank(1'b0);
        blank(1'b0);

        part_line(3'd2, 0, 7, 1'b0);
        blank(1'b0);
        blank(1'b0);

        part_line(3'd3, 0, 5, 1'b0);
        check_taps("b_y3x5", 24'h030500, 24'h020500, 24'h010500);
        chk("b_y3x5_opack", o_pack, mk(1'b0, 1'b1, 8'd3, 8'd0, 8'd5, 3'd5, 3'd3));
        part_line(3'd3, 6, 7, 1'b0);
        blank(1'b0);
        check_taps("b_blank1", 24'h030700, 24'h020700, 24'h010700);
        chk("b_blank1_opack", o_pack, '0);
        blank(1'b0);
        chk("b_blank2_line3", PW'(line3), PW'(24'h030700));

        // Line 4 ends in the same cycle vsync rises
        part_line(3'd4, 0, 7, 1'b0);
        blank(1'b1);
        chk("vs_edge_opack", o_pack, mk(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 3'd0, 3'd0));
        blank(1'b0);

        // Frame C
        part_line(3'd0, 0, 1, 1'b0);
        check_taps("c_y0x1", 24'h000100, ZERO_EN ? 24'h0 : 24'h040100, ZERO_EN ? 24'h0 : 24'h030100);
        part_line(3'd0, 2, 7, 1'b0);
        blank(1'b0);
        blank(1'b0);

        // Two-cycle reset in the middle of line 1
        part_line(3'd1, 0, 3, 1'b0);
        rst = 1'b1;
        pix(3'd4, 3'd1, 1'b0);
        chk("rst1_opack", o_pack, '0);
        check_taps("rst1", 24'h0, 24'h0, 24'h0);
        pix(3'd4, 3'd1, 1'b0);
        chk("rst2_opack", o_pack, '0);
        check_taps("rst2", 24'h0, 24'h0, 24'h0);
        rst = 1'b0;
        pix(3'd5, 3'd1, 1'b0);
        check_taps("c_y1x5", 24'h010500, ZERO_EN ? 24'h0 : 24'h000500, ZERO_EN ? 24'h0 : 24'h040500);
        part_line(3'd1, 6, 7, 1'b0);
        blank(1'b0);
        blank(1'b0);

        part_line(3'd2, 0, 5, 1'b0);
        check_taps("c_y2x5", 24'h020500, 24'h010500, ZERO_EN ? 24'h0 : 24'h000500);
        part_line(3'd2, 6, 7, 1'b0);
        blank(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
